// File: rtl/sample_mac_pipe.sv
// Pipelined signed multiplier with optional tagged accumulation and
// wrap/saturate reduction of the result to dout_WIDTH.
module sample_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 11,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 11,
    parameter int ACC_WIDTH  = 32,
    parameter int MODE       = 0,
    parameter int SAT        = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic                         acc_clr,
    input  logic                         acc_last,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         ovf
);

    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int D  = NUM_STAGE - 1;
    localparam logic signed [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    logic signed [din0_WIDTH-1:0] a_q;
    logic signed [din1_WIDTH-1:0] b_q;
    logic                         s1_v_q, s1_clr_q, s1_last_q;

    logic signed [PW-1:0]         prod_q  [D];
    logic                         pv_q    [D];
    logic                         pclr_q  [D];
    logic                         plast_q [D];

    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         wrap_q, emit_q;

    logic signed [dout_WIDTH-1:0] dout_q;
    logic                         dout_valid_q, ovf_q;

    logic signed [PW-1:0]         prod_d;
    logic signed [ACC_WIDTH-1:0]  tail_ext, acc_sum_d, red_in, red_hi;
    logic                         sum_wrap, red_take, red_fits, red_ovf_d;
    logic signed [dout_WIDTH-1:0] red_out_d;

    always_comb begin
        prod_d    = PW'(a_q) * PW'(b_q);
        tail_ext  = ACC_WIDTH'(prod_q[D-1]);
        acc_sum_d = acc_q + tail_ext;
        sum_wrap  = (acc_q[ACC_WIDTH-1] == tail_ext[ACC_WIDTH-1]) &&
                    (acc_sum_d[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        // MODE=1 reduces the accumulator one stage after it was updated
        red_in    = (MODE == 1) ? acc_q : tail_ext;
        red_take  = (MODE == 1) ? emit_q : pv_q[D-1];
        red_hi    = red_in >>> (dout_WIDTH - 1);
        red_fits  = (red_hi == '0) || (red_hi == '1);
        red_out_d = red_in[dout_WIDTH-1:0];
        if (SAT != 0 && !red_fits)
            red_out_d = red_in[ACC_WIDTH-1] ? DOUT_MIN : DOUT_MAX;
        red_ovf_d = !red_fits || (MODE == 1 && wrap_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            s1_v_q       <= 1'b0;
            s1_clr_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            for (int unsigned i = 0; i < D; i++) begin
                prod_q[i]  <= '0;
                pv_q[i]    <= 1'b0;
                pclr_q[i]  <= 1'b0;
                plast_q[i] <= 1'b0;
            end
            acc_q        <= '0;
            wrap_q       <= 1'b0;
            emit_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (ce) begin
            a_q       <= din0;
            b_q       <= din1;
            s1_v_q    <= in_valid;
            s1_clr_q  <= in_valid & acc_clr;
            s1_last_q <= in_valid & acc_last;

            prod_q[0]  <= prod_d;
            pv_q[0]    <= s1_v_q;
            pclr_q[0]  <= s1_clr_q;
            plast_q[0] <= s1_last_q;
            for (int unsigned i = 1; i < D; i++) begin
                prod_q[i]  <= prod_q[i-1];
                pv_q[i]    <= pv_q[i-1];
                pclr_q[i]  <= pclr_q[i-1];
                plast_q[i] <= plast_q[i-1];
            end

            if (MODE == 1 && pv_q[D-1]) begin
                if (pclr_q[D-1]) begin
                    acc_q  <= tail_ext;
                    wrap_q <= 1'b0;
                end else begin
                    acc_q  <= acc_sum_d;
                    wrap_q <= wrap_q | sum_wrap;
                end
            end
            emit_q <= (MODE == 1) && pv_q[D-1] && plast_q[D-1];

            dout_valid_q <= red_take;
            if (red_take) begin
                dout_q <= red_out_d;
                ovf_q  <= red_ovf_d;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_sample_mac_pipe.sv
// Directed checks of sample_mac_pipe across multiply, saturate, deep-pipe
// stall, accumulate and reset scenarios using several parameterisations.
module tb_sample_mac_pipe;

    logic clk = 1'b0;
    logic reset, ce, in_valid, acc_clr, acc_last;
    logic signed [10:0] din0, din1;

    logic signed [10:0] d0, d1, d2, d4;
    logic signed [15:0] d3;
    logic v0, v1, v2, v3, v4, o0, o1, o2, o3, o4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sample_mac_pipe #(.NUM_STAGE(2), .MODE(0), .SAT(0)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .acc_last(acc_last), .din0(din0), .din1(din1), .dout(d0), .dout_valid(v0), .ovf(o0));
    sample_mac_pipe #(.NUM_STAGE(2), .MODE(0), .SAT(1)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .acc_last(acc_last), .din0(din0), .din1(din1), .dout(d1), .dout_valid(v1), .ovf(o1));
    sample_mac_pipe #(.NUM_STAGE(4), .MODE(0), .SAT(0)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .acc_last(acc_last), .din0(din0), .din1(din1), .dout(d2), .dout_valid(v2), .ovf(o2));
    sample_mac_pipe #(.NUM_STAGE(2), .MODE(1), .dout_WIDTH(16)) u3 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .acc_last(acc_last), .din0(din0), .din1(din1), .dout(d3), .dout_valid(v3), .ovf(o3));
    sample_mac_pipe #(.NUM_STAGE(2), .MODE(1), .ACC_WIDTH(22)) u4 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .acc_clr(acc_clr),
        .acc_last(acc_last), .din0(din0), .din1(din1), .dout(d4), .dout_valid(v4), .ovf(o4));

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic signed [10:0] a,
                         input logic signed [10:0] b, input logic c, input logic l);
        in_valid = v; din0 = a; din1 = b; acc_clr = c; acc_last = l;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        step(); step();
        reset = 1'b0;
        check_val("rst_dout",  d0, 0);
        check_val("rst_valid", v0, 0);
        check_val("rst_ovf",   o0, 0);
        check_val("rst_acc_valid", v3, 0);

        // basic multiply, NUM_STAGE=2
        drive(1, 3, -5, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        check_val("m0_e0_valid", v0, 0);
        step(); check_val("m0_e1_valid", v0, 0);
        step();
        check_val("m0_e2_valid", v0, 1);
        check_val("m0_e2_dout",  d0, -15);
        check_val("m0_e2_ovf",   o0, 0);
        step();
        check_val("m0_e3_valid", v0, 0);
        check_val("m0_e3_hold",  d0, -15);

        // wrap vs saturate
        drive(1, 1023, 1023, 0, 0); step();
        drive(1, -1024, 1023, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        check_val("wrap_pos_dout", d0, 1);
        check_val("wrap_pos_ovf",  o0, 1);
        check_val("sat_pos_dout",  d1, 1023);
        check_val("sat_pos_ovf",   o1, 1);
        step();
        check_val("wrap_neg_valid", v0, 1);
        check_val("wrap_neg_dout", d0, -1024);
        check_val("wrap_neg_ovf",  o0, 1);
        check_val("sat_neg_dout",  d1, -1024);
        check_val("sat_neg_ovf",   o1, 1);
        step();
        check_val("wrap_idle_valid", v0, 0);

        // NUM_STAGE=4 stream with a two-cycle stall
        do_reset();
        drive(1, 1, 1, 0, 0); step();
        drive(1, 2, 2, 0, 0); step();
        drive(0, 0, 0, 0, 0); ce = 1'b0;
        step(); check_val("p4_stall1_valid", v2, 0);
        step(); check_val("p4_stall2_valid", v2, 0);
        ce = 1'b1; drive(1, 3, 3, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        step(); check_val("p4_e3_valid", v2, 0);
        step(); check_val("p4_e4_valid", v2, 1); check_val("p4_e4_dout", d2, 1);
        ce = 1'b0;
        step(); check_val("p4_frz_valid", v2, 1); check_val("p4_frz_dout", d2, 1);
        ce = 1'b1;
        step(); check_val("p4_e5_valid", v2, 1); check_val("p4_e5_dout", d2, 4);
        step(); check_val("p4_e6_valid", v2, 1); check_val("p4_e6_dout", d2, 9);
        check_val("p4_e6_ovf", o2, 0);
        step(); check_val("p4_e7_valid", v2, 0); check_val("p4_e7_hold", d2, 9);

        // accumulate: 6+20-6=20, then single-sample 49
        do_reset();
        drive(1, 2, 3, 1, 0); step(); check_val("acc_e0_valid", v3, 0);
        drive(1, 4, 5, 0, 0); step(); check_val("acc_e1_valid", v3, 0);
        drive(1, -1, 6, 0, 1); step(); check_val("acc_e2_valid", v3, 0);
        drive(1, 7, 7, 1, 1); step(); check_val("acc_e3_valid", v3, 0);
        drive(0, 0, 0, 0, 0);
        step(); check_val("acc_e4_valid", v3, 0);
        step();
        check_val("acc_e5_valid", v3, 1);
        check_val("acc_e5_dout",  d3, 20);
        check_val("acc_e5_ovf",   o3, 0);
        step();
        check_val("acc_e6_valid", v3, 1);
        check_val("acc_e6_dout",  d3, 49);
        check_val("acc_e6_ovf",   o3, 0);
        step(); check_val("acc_e7_valid", v3, 0);

        // accumulator wrap: 4 * 2^20 in 22 bits
        do_reset();
        drive(1, -1024, -1024, 1, 0); step();
        drive(1, -1024, -1024, 0, 0); step();
        drive(1, -1024, -1024, 0, 0); step();
        drive(1, -1024, -1024, 0, 1); step();
        drive(0, 0, 0, 0, 0);
        step(); check_val("aw_e4_valid", v4, 0);
        step(); check_val("aw_e5_valid", v4, 0);
        step();
        check_val("aw_e6_valid", v4, 1);
        check_val("aw_e6_dout",  d4, 0);
        check_val("aw_e6_ovf",   o4, 1);
        check_val("at_e6_dout",  d3, 0);
        check_val("at_e6_ovf",   o3, 1);

        // reset mid-stream, with ce low to show reset priority
        do_reset();
        drive(1, 5, 5, 0, 0); step();
        drive(1, 6, 6, 0, 0); step();
        drive(1, 7, 7, 0, 0); step();
        drive(1, 8, 8, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        check_val("mr_pre_valid", v2, 1);
        check_val("mr_pre_dout",  d2, 25);
        ce = 1'b0; reset = 1'b1; step();
        check_val("mr_rst_valid", v2, 0);
        check_val("mr_rst_dout",  d2, 0);
        check_val("mr_rst_ovf",   o2, 0);
        ce = 1'b1; reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); check_val("mr_flush_valid", v2, 0);
        end
        drive(1, -8, 9, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(); check_val("mr_lat_valid", v2, 0);
        end
        step();
        check_val("mr_new_valid", v2, 1);
        check_val("mr_new_dout",  d2, -72);
        check_val("mr_new_ovf",   o2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
